// File: rtl/quad_step_if.sv
// Encoder front-end bus: pin inputs and enable toward the decoder, step/error
// strobes and the error count back out.
interface quad_step_if #(
  parameter int ERR_WIDTH = 8
);
  logic                 enable;
  logic                 quad_a;
  logic                 quad_b;
  logic                 step_en;
  logic                 step_up_down;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (
    output enable, quad_a, quad_b,
    input  step_en, step_up_down, err, err_count
  );

  modport slave (
    input  enable, quad_a, quad_b,
    output step_en, step_up_down, err, err_count
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchroniser, optional glitch filter (QDEC_GLITCH_FILTER_EN),
// Gray-step decode into step_en/step_up_down, illegal-transition strobe and counter.
//
// state  | meaning
// PRIME  | first cycle after reset, capture current pins
// WAIT   | let sync/filter pipeline flush reset zeros, keep reloading prev
// TRACK  | decode each change of {a,b} against prev
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int ERR_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  quad_step_if.slave  bus
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int WAIT_LEN = SYNC_STAGES + FILT_CYCLES;
`else
  localparam int WAIT_LEN = SYNC_STAGES;
`endif
  localparam int WW = $clog2(WAIT_LEN + 1);

  typedef enum logic [1:0] {ST_PRIME, ST_WAIT, ST_TRACK} state_t;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic                   a_s, b_s, a_f, b_f;
  logic [1:0]             cur, prev;
  state_t                 state;
  logic [WW-1:0]          wait_cnt;
  logic                   step_en_r, dir_r, err_r;
  logic [ERR_WIDTH-1:0]   err_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], bus.quad_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], bus.quad_b};
    end
  end

  assign a_s = a_sync[SYNC_STAGES-1];
  assign b_s = b_sync[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [FW-1:0] a_cnt, b_cnt;

  // A channel flips only after FILT_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_f   <= 1'b0;
      b_f   <= 1'b0;
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_s == a_f) begin
        a_cnt <= '0;
      end else if (a_cnt == FW'(FILT_CYCLES - 1)) begin
        a_f   <= a_s;
        a_cnt <= '0;
      end else begin
        a_cnt <= a_cnt + FW'(1);
      end
      if (b_s == b_f) begin
        b_cnt <= '0;
      end else if (b_cnt == FW'(FILT_CYCLES - 1)) begin
        b_f   <= b_s;
        b_cnt <= '0;
      end else begin
        b_cnt <= b_cnt + FW'(1);
      end
    end
  end
`else
  assign a_f = a_s;
  assign b_f = b_s;
`endif

  assign cur = {a_f, b_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PRIME;
      prev      <= 2'b00;
      wait_cnt  <= '0;
      step_en_r <= 1'b0;
      dir_r     <= 1'b1;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      step_en_r <= 1'b0;
      err_r     <= 1'b0;
      prev      <= cur;
      case (state)
        ST_PRIME: begin
          wait_cnt <= WW'(WAIT_LEN - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_TRACK;
          else                wait_cnt <= wait_cnt - WW'(1);
        end
        ST_TRACK: begin
          if (bus.enable) begin
            case ({prev, cur})
              4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                step_en_r <= 1'b1;
                dir_r     <= 1'b1;
              end
              4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                step_en_r <= 1'b1;
                dir_r     <= 1'b0;
              end
              4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
                err_r <= 1'b1;
                if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + ERR_WIDTH'(1);
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_PRIME;
      endcase
    end
  end

  assign bus.step_en      = step_en_r;
  assign bus.step_up_down = dir_r;
  assign bus.err          = err_r;
  assign bus.err_count    = err_cnt_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboarded bench for quad_step_decoder; honours QDEC_GLITCH_FILTER_EN for latency.
module tb_quad_step_decoder;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = 10;

  typedef struct {
    int cyc;
    bit is_err;
    bit dir;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pos = 0;
  exp_t sb[$];

  logic [1:0] m_prev;
  bit         m_dir;
  int         m_cnt;

  quad_step_if #(.ERR_WIDTH(8)) qif ();

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .ERR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (qif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_pulse: required at cyc=%0d, still absent at cyc=%0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (qif.step_en && qif.err) begin
        total++; bad++;
        $display("FAIL step_err_overlap: both high at cyc=%0d, required at most one", cyc);
      end
      if (qif.step_en || qif.err) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: step=%b err=%b at cyc=%0d, required none",
                   qif.step_en, qif.err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (qif.err !== e.is_err || cyc != e.cyc || qif.step_up_down !== e.dir ||
              qif.err_count !== 8'(e.cnt)) begin
            bad++;
            $display("FAIL pulse: got err=%b cyc=%0d dir=%b cnt=%0d, required err=%b cyc=%0d dir=%b cnt=%0d",
                     qif.err, cyc, qif.step_up_down, qif.err_count, e.is_err, e.cyc, e.dir, e.cnt);
          end
        end
        if (qif.step_en) pos += qif.step_up_down ? 1 : -1;
      end
    end
  end

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive_edge(input logic [1:0] ab, input int gap);
    int d;
    @(negedge clk);
    {qif.quad_a, qif.quad_b} = ab;
    d = (gidx(ab) - gidx(m_prev) + 4) % 4;
    if (qif.enable) begin
      if (d == 1) begin
        m_dir = 1'b1;
        sb.push_back('{cyc + LAT, 1'b0, 1'b1, m_cnt});
      end else if (d == 3) begin
        m_dir = 1'b0;
        sb.push_back('{cyc + LAT, 1'b0, 1'b0, m_cnt});
      end else if (d == 2) begin
        if (m_cnt < 255) m_cnt++;
        sb.push_back('{cyc + LAT, 1'b1, m_dir, m_cnt});
      end
    end
    m_prev = ab;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d pulses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1;
    {qif.quad_a, qif.quad_b} = ab;
    repeat (3) @(negedge clk);
    total += 4;
    if (qif.step_en !== 1'b0) begin bad++; $display("FAIL rst_step_en: got %b, required 0", qif.step_en); end
    if (qif.step_up_down !== 1'b1) begin bad++; $display("FAIL rst_dir: got %b, required 1", qif.step_up_down); end
    if (qif.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", qif.err); end
    if (qif.err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count: got %0d, required 0", qif.err_count); end
    rst = 1'b0;
    m_prev = ab;
    m_dir  = 1'b1;
    m_cnt  = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    pos = 0;
    for (int i = 0; i < 8; i++) drive_edge(seq[i % 4], GAP);
    wait_drain("forward");
    total += 3;
    if (pos != 8) begin bad++; $display("FAIL fwd_position: got %0d, required 8", pos); end
    if (qif.step_up_down !== 1'b1) begin bad++; $display("FAIL fwd_dir: got %b, required 1", qif.step_up_down); end
    if (qif.err_count !== 8'd0) begin bad++; $display("FAIL fwd_err_count: got %0d, required 0", qif.err_count); end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) drive_edge(seq[i], GAP);
    wait_drain("reverse");
    total += 2;
    if (pos != 4) begin bad++; $display("FAIL rev_position: got %0d, required 4", pos); end
    if (qif.step_up_down !== 1'b0) begin bad++; $display("FAIL rev_dir: got %b, required 0", qif.step_up_down); end
  endtask

  task automatic test_illegal();
    drive_edge(2'b11, GAP);
    wait_drain("illegal");
    total += 2;
    if (qif.err_count !== 8'd1) begin bad++; $display("FAIL ill_err_count: got %0d, required 1", qif.err_count); end
    if (qif.step_up_down !== 1'b0) begin bad++; $display("FAIL ill_dir: got %b, required 0", qif.step_up_down); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) drive_edge((i % 2 == 0) ? 2'b00 : 2'b11, GAP);
    wait_drain("saturate");
    total++;
    if (qif.err_count !== 8'd255) begin bad++; $display("FAIL sat_err_count: got %0d, required 255", qif.err_count); end
  endtask

  task automatic test_filter();
    test_reset(2'b00);
    @(negedge clk);
    qif.quad_a = 1'b1;
    repeat (3) @(negedge clk);
    qif.quad_a = 1'b0;
    repeat (20) @(negedge clk);
    pos = 0;
    drive_edge(2'b10, 5);
    drive_edge(2'b00, GAP);
    wait_drain("filter");
    total++;
    if (pos != 0) begin bad++; $display("FAIL filt_position: got %0d, required 0", pos); end
  endtask

  task automatic test_enable();
    @(negedge clk);
    qif.enable = 1'b0;
    test_reset(2'b11);
    drive_edge(2'b01, GAP);
    drive_edge(2'b00, GAP);
    total += 2;
    if (qif.step_up_down !== 1'b1) begin bad++; $display("FAIL dis_dir_hold: got %b, required 1", qif.step_up_down); end
    if (qif.err_count !== 8'd0) begin bad++; $display("FAIL dis_err_count: got %0d, required 0", qif.err_count); end
    @(negedge clk);
    qif.enable = 1'b1;
    repeat (5) @(negedge clk);
    pos = 0;
    drive_edge(2'b01, GAP);
    wait_drain("enable");
    total++;
    if (pos != 1) begin bad++; $display("FAIL en_position: got %0d, required 1", pos); end
  endtask

  initial begin
    rst = 1'b1;
    qif.enable = 1'b1;
    qif.quad_a = 1'b0;
    qif.quad_b = 1'b0;
    test_reset(2'b00);
    test_forward();
    test_reverse();
    test_illegal();
    test_saturate();
`ifdef QDEC_GLITCH_FILTER_EN
    test_filter();
`endif
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
